lfsr_rand_gen: RTL and testbench

Parametrised pseudo-random source built on an XNOR Fibonacci LFSR. It adds a request/response handshake that returns a uniformly distributed number in [0, range_max] using masked rejection sampling, with a bounded-retry fallback. It also provides lock-up protection and a full-period pulse. Game logic (map fill, power-up drops, enemy AI) draws from it through the request port.

---
 rtl/lfsr_rand_gen.sv | 190 +++++++++++++++++++
 tb/tb_lfsr_rand_gen.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rand_gen.sv
// lfsr_rand_gen: XNOR Fibonacci LFSR pseudo-random source.
// Draws in [0, range_max] are produced by masked rejection sampling with a
// bounded-retry fallback. Also provides lock-up protection for all-ones
// seeds and a one-cycle pulse whenever the sequence wraps to the last seed.
module lfsr_rand_gen #(
  parameter int N_BITS     = 16,
  parameter int OUT_BITS   = 8,
  parameter int MAX_REJECT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                seed_dv,
  input  logic [N_BITS-1:0]   seed_data,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [OUT_BITS-1:0] range_max,
  output logic                rnd_valid,
  input  logic                rnd_ready,
  output logic [OUT_BITS-1:0] rnd_data,
  output logic                rnd_fallback,
  output logic [N_BITS-1:0]   lfsr_state,
  output logic                period_done
);

  // Elaboration-time parameter legality checks.
  if (!(N_BITS == 8 || N_BITS == 12 || N_BITS == 16 || N_BITS == 24 || N_BITS == 32)) begin : g_bad_n_bits
    $error("lfsr_rand_gen: N_BITS must be one of 8, 12, 16, 24, 32");
  end
  if (OUT_BITS < 1 || OUT_BITS > N_BITS) begin : g_bad_out_bits
    $error("lfsr_rand_gen: OUT_BITS must be in 1..N_BITS");
  end
  if (MAX_REJECT < 1 || MAX_REJECT > 255) begin : g_bad_max_reject
    $error("lfsr_rand_gen: MAX_REJECT must be in 1..255");
  end

  // Feedback tap positions as a bit mask (tap t maps to bit t-1).
  function automatic logic [N_BITS-1:0] f_tap_mask();
    logic [31:0] m;
    case (N_BITS)
      8:       m = 32'h0000_00B8;  // 8,6,5,4
      12:      m = 32'h0000_0829;  // 12,6,4,1
      16:      m = 32'h0000_D008;  // 16,15,13,4
      24:      m = 32'h00E1_0000;  // 24,23,22,17
      32:      m = 32'h8020_0003;  // 32,22,2,1
      default: m = 32'h0000_0000;
    endcase
    return m[N_BITS-1:0];
  endfunction

  // Smallest 2^k-1 that covers r: smear the highest set bit downwards.
  function automatic logic [OUT_BITS-1:0] f_cover_mask(input logic [OUT_BITS-1:0] r);
    logic [OUT_BITS-1:0] m;
    m = r;
    for (int i = 1; i < OUT_BITS; i++) begin
      m = m | (r >> i);
    end
    return m;
  endfunction

  // The all-ones state locks an XNOR LFSR, so such a seed is replaced by 0.
  function automatic logic [N_BITS-1:0] f_legal_seed(input logic [N_BITS-1:0] s);
    return (&s) ? '0 : s;
  endfunction

  localparam logic [N_BITS-1:0] TAP_MASK  = f_tap_mask();
  localparam logic [7:0]        REJ_LIMIT = 8'(MAX_REJECT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  logic [N_BITS-1:0]     r_lfsr;
  logic [N_BITS-1:0]     r_seed;
  logic                  r_period;
  logic [OUT_BITS-1:0]   r_range;
  logic [OUT_BITS-1:0]   r_mask;
  logic [7:0]            r_rej;
  logic [OUT_BITS-1:0]   r_data;
  logic                  r_fallback;

  state_t                w_state_nxt;
  logic [OUT_BITS-1:0]   w_range_nxt;
  logic [OUT_BITS-1:0]   w_mask_nxt;
  logic [7:0]            w_rej_nxt;
  logic [OUT_BITS-1:0]   w_data_nxt;
  logic                  w_fallback_nxt;

  logic                  w_step;
  logic                  w_fb;
  logic [N_BITS-1:0]     w_lfsr_step;
  logic [N_BITS-1:0]     w_seed_legal;
  logic [OUT_BITS-1:0]   w_cand;

  assign w_step       = en | (r_state == S_DRAW);
  assign w_fb         = ~(^(r_lfsr & TAP_MASK));
  assign w_lfsr_step  = {r_lfsr[N_BITS-2:0], w_fb};
  assign w_seed_legal = f_legal_seed(seed_data);
  assign w_cand       = r_lfsr[OUT_BITS-1:0] & r_mask;

  // LFSR register: seed load wins over stepping; wrap detection is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr   <= '0;
      r_seed   <= '0;
      r_period <= 1'b0;
    end else begin
      r_period <= 1'b0;
      if (seed_dv) begin
        r_lfsr <= w_seed_legal;
        r_seed <= w_seed_legal;
      end else if (w_step) begin
        r_lfsr   <= w_lfsr_step;
        r_period <= (w_lfsr_step == r_seed);
      end
    end
  end

  // Draw FSM state and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_range    <= '0;
      r_mask     <= '0;
      r_rej      <= '0;
      r_data     <= '0;
      r_fallback <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_range    <= w_range_nxt;
      r_mask     <= w_mask_nxt;
      r_rej      <= w_rej_nxt;
      r_data     <= w_data_nxt;
      r_fallback <= w_fallback_nxt;
    end
  end

  // Draw FSM next-state: accept in IDLE, sample/reject in DRAW, hold in RESP.
  always_comb begin
    w_state_nxt    = r_state;
    w_range_nxt    = r_range;
    w_mask_nxt     = r_mask;
    w_rej_nxt      = r_rej;
    w_data_nxt     = r_data;
    w_fallback_nxt = r_fallback;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_range_nxt = range_max;
          w_mask_nxt  = f_cover_mask(range_max);
          w_rej_nxt   = '0;
          w_state_nxt = S_DRAW;
        end
      end
      S_DRAW: begin
        if (w_cand <= r_range) begin
          w_data_nxt     = w_cand;
          w_fallback_nxt = 1'b0;
          w_state_nxt    = S_RESP;
        end else if (r_rej == REJ_LIMIT) begin
          // Halving a masked value always lands below range_max.
          w_data_nxt     = w_cand >> 1;
          w_fallback_nxt = 1'b1;
          w_state_nxt    = S_RESP;
        end else begin
          w_rej_nxt = r_rej + 8'd1;
        end
      end
      S_RESP: begin
        if (rnd_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign req_ready    = (r_state == S_IDLE);
  assign rnd_valid    = (r_state == S_RESP);
  assign rnd_data     = r_data;
  assign rnd_fallback = r_fallback;
  assign lfsr_state   = r_lfsr;
  assign period_done  = r_period;

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Directed bench for lfsr_rand_gen: a 16-bit instance with default draw
// settings and an 8-bit instance with MAX_REJECT=1 for period/fallback cases.
module tb_lfsr_rand_gen;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // Instance A: N_BITS=16, OUT_BITS=8, MAX_REJECT=15
  logic        a_en, a_seed_dv, a_req_valid, a_rnd_ready;
  logic [15:0] a_seed;
  logic [7:0]  a_range;
  logic        a_req_ready, a_rnd_valid, a_rnd_fb, a_period;
  logic [7:0]  a_rnd_data;
  logic [15:0] a_lfsr;

  // Instance B: N_BITS=8, OUT_BITS=8, MAX_REJECT=1
  logic        b_en, b_seed_dv, b_req_valid, b_rnd_ready;
  logic [7:0]  b_seed;
  logic [7:0]  b_range;
  logic        b_req_ready, b_rnd_valid, b_rnd_fb, b_period;
  logic [7:0]  b_rnd_data;
  logic [7:0]  b_lfsr;

  lfsr_rand_gen #(.N_BITS(16), .OUT_BITS(8), .MAX_REJECT(15)) u_a (
    .clk(clk), .rst(rst), .en(a_en), .seed_dv(a_seed_dv), .seed_data(a_seed),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .range_max(a_range),
    .rnd_valid(a_rnd_valid), .rnd_ready(a_rnd_ready), .rnd_data(a_rnd_data),
    .rnd_fallback(a_rnd_fb), .lfsr_state(a_lfsr), .period_done(a_period)
  );

  lfsr_rand_gen #(.N_BITS(8), .OUT_BITS(8), .MAX_REJECT(1)) u_b (
    .clk(clk), .rst(rst), .en(b_en), .seed_dv(b_seed_dv), .seed_data(b_seed),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .range_max(b_range),
    .rnd_valid(b_rnd_valid), .rnd_ready(b_rnd_ready), .rnd_data(b_rnd_data),
    .rnd_fallback(b_rnd_fb), .lfsr_state(b_lfsr), .period_done(b_period)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] step_seq [4];
    int lat;
    int pulses;
    int ff_seen;

    step_seq[0] = 16'h0003;
    step_seq[1] = 16'h0007;
    step_seq[2] = 16'h000F;
    step_seq[3] = 16'h001E;

    rst = 1'b1;
    a_en = 0; a_seed_dv = 0; a_seed = '0; a_req_valid = 0; a_range = '0; a_rnd_ready = 0;
    b_en = 0; b_seed_dv = 0; b_seed = '0; b_req_valid = 0; b_range = '0; b_rnd_ready = 0;
    tick();
    tick();

    // Reset state
    chk("rst_lfsr", a_lfsr, 16'h0000);
    chk("rst_req_ready", a_req_ready, 1);
    chk("rst_rnd_valid", a_rnd_valid, 0);
    chk("rst_rnd_data", a_rnd_data, 0);
    chk("rst_fallback", a_rnd_fb, 0);
    chk("rst_period", a_period, 0);
    chk("rst_b_lfsr", b_lfsr, 0);
    chk("rst_b_req_ready", b_req_ready, 1);
    rst = 1'b0;

    // Seed 0x0001 then four free-run steps
    a_seed_dv = 1; a_seed = 16'h0001;
    tick();
    chk("seed1_lfsr", a_lfsr, 16'h0001);
    chk("seed1_period", a_period, 0);
    a_seed_dv = 0; a_en = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("step_seq", a_lfsr, step_seq[i]);
    end
    a_en = 0;

    // One rejection: state 0x001E, range 5 -> cand 6 rejected, then 0x003C -> cand 4
    a_req_valid = 1; a_range = 8'd5;
    tick();
    chk("rej_req_ready", a_req_ready, 0);
    chk("rej_valid0", a_rnd_valid, 0);
    a_req_valid = 0; a_range = 8'hAA;
    tick();
    chk("rej_valid1", a_rnd_valid, 0);
    chk("rej_lfsr1", a_lfsr, 16'h003C);
    tick();
    chk("rej_valid2", a_rnd_valid, 1);
    chk("rej_data", a_rnd_data, 8'd4);
    chk("rej_fb", a_rnd_fb, 0);
    chk("rej_lfsr2", a_lfsr, 16'h0078);
    a_rnd_ready = 1;
    tick();
    chk("rej_done_valid", a_rnd_valid, 0);
    chk("rej_done_ready", a_req_ready, 1);
    chk("rej_no_step", a_lfsr, 16'h0078);
    a_rnd_ready = 0;

    // All-ones seed loads as zero and steps like seed 0
    a_seed_dv = 1; a_seed = 16'hFFFF;
    tick();
    chk("ones_lfsr", a_lfsr, 16'h0000);
    chk("ones_period", a_period, 0);
    a_seed_dv = 0; a_en = 1;
    tick();
    chk("ones_step1", a_lfsr, 16'h0001);
    tick();
    chk("ones_step2", a_lfsr, 16'h0003);
    a_en = 0;

    // range_max = 0: valid at T+2, held while rnd_ready low, req ignored
    a_req_valid = 1; a_range = 8'd0;
    tick();
    chk("r0_req_ready", a_req_ready, 0);
    a_req_valid = 0; a_range = 8'h7F;
    tick();
    chk("r0_valid", a_rnd_valid, 1);
    chk("r0_data", a_rnd_data, 0);
    chk("r0_fb", a_rnd_fb, 0);
    chk("r0_lfsr", a_lfsr, 16'h0007);
    a_req_valid = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("r0_hold_valid", a_rnd_valid, 1);
      chk("r0_hold_data", a_rnd_data, 0);
      chk("r0_hold_fb", a_rnd_fb, 0);
      chk("r0_hold_ready", a_req_ready, 0);
    end
    a_req_valid = 0; a_rnd_ready = 1;
    tick();
    chk("r0_done_valid", a_rnd_valid, 0);
    chk("r0_done_ready", a_req_ready, 1);
    a_rnd_ready = 0;

    // 1000 draws with range_max = 128
    for (int n = 0; n < 1000; n++) begin
      a_req_valid = 1; a_range = 8'd128;
      tick();
      a_req_valid = 0;
      lat = 1;
      while (a_rnd_valid !== 1'b1 && lat < 40) begin
        tick();
        lat++;
      end
      chk("draw_valid", a_rnd_valid, 1);
      chk("draw_le128", (a_rnd_data <= 8'd128), 1);
      chk("draw_latency", (lat >= 2 && lat <= 17), 1);
      if (a_rnd_fb === 1'b1) begin
        chk("draw_fb_le127", (a_rnd_data <= 8'd127), 1);
        chk("draw_fb_latency", lat, 17);
      end
      a_rnd_ready = 1;
      tick();
      a_rnd_ready = 0;
    end

    // 8-bit period: pulse every 255 steps, 0xFF never visited
    b_seed_dv = 1; b_seed = 8'h01;
    tick();
    chk("b_seed_lfsr", b_lfsr, 8'h01);
    chk("b_seed_period", b_period, 0);
    b_seed_dv = 0; b_en = 1;
    pulses = 0;
    ff_seen = 0;
    for (int i = 1; i <= 765; i++) begin
      tick();
      if (b_lfsr === 8'hFF) ff_seen++;
      if (b_period === 1'b1) begin
        pulses++;
        chk("per_position", i % 255, 0);
        chk("per_state", b_lfsr, 8'h01);
      end
    end
    chk("per_pulses", pulses, 3);
    chk("per_no_ff", ff_seen, 0);
    b_en = 0;

    // Fallback with MAX_REJECT=1: seed 0x03, range 2 -> two rejects, data 3>>1
    b_seed_dv = 1; b_seed = 8'h03;
    tick();
    chk("fb_seed", b_lfsr, 8'h03);
    b_seed_dv = 0; b_req_valid = 1; b_range = 8'd2;
    tick();
    chk("fb_req_ready", b_req_ready, 0);
    b_req_valid = 0;
    tick();
    chk("fb_valid1", b_rnd_valid, 0);
    chk("fb_lfsr1", b_lfsr, 8'h07);
    tick();
    chk("fb_valid2", b_rnd_valid, 1);
    chk("fb_data", b_rnd_data, 8'd1);
    chk("fb_flag", b_rnd_fb, 1);
    chk("fb_lfsr2", b_lfsr, 8'h0F);
    b_rnd_ready = 1;
    tick();
    chk("fb_done_valid", b_rnd_valid, 0);
    b_rnd_ready = 0;

    // Reset while in DRAW, then seed load together with a request
    a_seed_dv = 1; a_seed = 16'h1234;
    tick();
    chk("mid_seed", a_lfsr, 16'h1234);
    a_seed_dv = 0; a_req_valid = 1; a_range = 8'hFF;
    tick();
    chk("mid_in_draw", a_req_ready, 0);
    a_req_valid = 0; rst = 1;
    tick();
    chk("mid_rst_valid", a_rnd_valid, 0);
    chk("mid_rst_ready", a_req_ready, 1);
    chk("mid_rst_lfsr", a_lfsr, 16'h0000);
    chk("mid_rst_data", a_rnd_data, 0);
    chk("mid_rst_fb", a_rnd_fb, 0);
    chk("mid_rst_period", a_period, 0);
    rst = 0;
    a_seed_dv = 1; a_seed = 16'h00A5; a_req_valid = 1; a_range = 8'hFF;
    tick();
    chk("post_lfsr", a_lfsr, 16'h00A5);
    chk("post_req_ready", a_req_ready, 0);
    a_seed_dv = 0; a_req_valid = 0;
    tick();
    chk("post_valid", a_rnd_valid, 1);
    chk("post_data", a_rnd_data, 8'hA5);
    chk("post_fb", a_rnd_fb, 0);
    chk("post_lfsr_step", a_lfsr, 16'h014B);
    a_rnd_ready = 1;
    tick();
    chk("post_done_valid", a_rnd_valid, 0);
    a_rnd_ready = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
